disaggregator: RTL and testbench

- Inverse of the fetch-side aggregator: accepts one packed word of up to FETCH_WIDTH lanes from an upstream FIFO and emits its lanes one per cycle into a narrow downstream FIFO, lane 0 first.
- Used on the write-back and readout paths, where wide leaf or patch words must return to DATA_WIDTH-wide streams.
- Lane count is runtime-selectable and matches the aggregator's change_fetch_width / input_fetch_width control.

---
 rtl/disaggregator_pkg.sv | 17 +
 rtl/disaggregator_fetch_width_ctrl.sv | 40 ++++
 rtl/disaggregator.sv | 99 +++++++++
 tb/tb_disaggregator.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disaggregator_pkg.sv
// Shared definitions for the fetch-side aggregator and the write-back disaggregator.
package disaggregator_pkg;

  localparam int DATA_WIDTH_DEF  = 16;
  localparam int FETCH_WIDTH_DEF = 6;

  // Counter wide enough to hold the value FETCH_WIDTH itself, not just lane indices.
  function automatic int cnt_width(input int fetch_width);
    return $clog2(fetch_width + 1);
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/disaggregator_fetch_width_ctrl.sv
// Active lane-count register with a deferred update that lands on word boundaries.
module disaggregator_fetch_width_ctrl #(
  parameter int FETCH_WIDTH = 6,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             change_fetch_width,
  input  logic [CNT_W-1:0] input_fetch_width,
  input  logic             apply_now,
  input  logic             word_done,
  output logic [CNT_W-1:0] width_r
);

  logic [CNT_W-1:0] pend_w;
  logic             pend_v;
  logic             legal;

  assign legal = change_fetch_width
               & (input_fetch_width != '0)
               & (input_fetch_width <= CNT_W'(FETCH_WIDTH));

  // A request made while a word is in flight waits for that word's final lane.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      width_r <= CNT_W'(FETCH_WIDTH);
      pend_v  <= 1'b0;
    end else if (legal && (apply_now || word_done)) begin
      width_r <= input_fetch_width;
      pend_v  <= 1'b0;
    end else if (legal) begin
      pend_w <= input_fetch_width;
      pend_v <= 1'b1;
    end else if (word_done && pend_v) begin
      width_r <= pend_w;
      pend_v  <= 1'b0;
    end
  end

endmodule

// File: rtl/disaggregator.sv
// Splits a packed multi-lane word from a wide FIFO into one DATA_WIDTH lane per cycle.
module disaggregator
  import disaggregator_pkg::*;
#(
  parameter  int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter  int FETCH_WIDTH = FETCH_WIDTH_DEF,
  localparam int CNT_W       = cnt_width(FETCH_WIDTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [DATA_WIDTH-1:0]             receiver_data,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq,
  output logic                              receiver_last,
  input  logic                              change_fetch_width,
  input  logic [CNT_W-1:0]                  input_fetch_width
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] lane_r, lane_nxt;
  logic [CNT_W-1:0] width_r;
  logic             last;
  logic             load_hold;
  logic [DATA_WIDTH-1:0] hold [FETCH_WIDTH];

  disaggregator_fetch_width_ctrl #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .CNT_W       (CNT_W)
  ) u_width_ctrl (
    .clk                (clk),
    .rst_n              (rst_n),
    .change_fetch_width (change_fetch_width),
    .input_fetch_width  (input_fetch_width),
    .apply_now          ((state == IDLE) && !sender_deq),
    .word_done          (receiver_last),
    .width_r            (width_r)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      lane_r <= '0;
    end else begin
      state  <= state_nxt;
      lane_r <= lane_nxt;
    end
  end

  // Reloading on the last-lane cycle keeps back-to-back words bubble-free.
  always_comb begin
    receiver_enq  = rst_n && (state == SHIFT) && receiver_full_n;
    last          = (lane_r == width_r - CNT_W'(1));
    receiver_last = receiver_enq && last;
    sender_deq    = rst_n && sender_empty_n && ((state == IDLE) || receiver_last);
    state_nxt     = state;
    lane_nxt      = lane_r;
    load_hold     = 1'b0;
    case (state)
      IDLE: begin
        if (sender_deq) begin
          load_hold = 1'b1;
          lane_nxt  = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (receiver_enq) begin
          if (!last) begin
            lane_nxt = lane_r + CNT_W'(1);
          end else begin
            lane_nxt = '0;
            if (sender_deq) load_hold = 1'b1;
            else            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load_hold) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        hold[i] <= sender_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    receiver_data = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (lane_r == CNT_W'(i)) receiver_data = hold[i];
    end
  end

endmodule

// File: tb/tb_disaggregator.sv
// Directed bench for disaggregator: a word-level model predicts every lane and handshake.
module tb_disaggregator;

  localparam int DW = 16;
  localparam int FW = 6;
  localparam int CW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } lane_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [FW*DW-1:0]  sender_data;
  logic              sender_empty_n;
  logic              sender_deq;
  logic [DW-1:0]     receiver_data;
  logic              receiver_full_n;
  logic              receiver_enq;
  logic              receiver_last;
  logic              change_fetch_width;
  logic [CW-1:0]     input_fetch_width;

  always #5 clk = ~clk;

  disaggregator #(
    .DATA_WIDTH  (DW),
    .FETCH_WIDTH (FW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .sender_data        (sender_data),
    .sender_empty_n     (sender_empty_n),
    .sender_deq         (sender_deq),
    .receiver_data      (receiver_data),
    .receiver_full_n    (receiver_full_n),
    .receiver_enq       (receiver_enq),
    .receiver_last      (receiver_last),
    .change_fetch_width (change_fetch_width),
    .input_fetch_width  (input_fetch_width)
  );

  logic [FW*DW-1:0] up_q[$];
  lane_t            exp_q[$];
  int               model_width = FW;
  int               tests = 0;
  int               fails = 0;
  int               cyc = 0;

  logic [DW-1:0] log_d[$];
  bit            log_l[$];
  int            enq_cyc[$];
  int            deq_cyc[$];
  logic [DW-1:0] exp_d[$];
  bit            exp_l[$];

  bit            s_rst = 1'b0;
  bit            s_pop_up = 1'b0;
  bit            s_pop_exp = 1'b0;
  bit            s_chg = 1'b0;
  logic [CW-1:0] s_in = '0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
    end
  endtask

  task automatic refreshSender();
    sender_empty_n = (up_q.size() != 0);
    sender_data    = (up_q.size() != 0) ? up_q[0] : '0;
  endtask

  function automatic logic [FW*DW-1:0] mkWord(input logic [DW-1:0] base);
    logic [FW*DW-1:0] w;
    for (int i = 0; i < FW; i++) w[i*DW +: DW] = base + DW'(i);
    return w;
  endfunction

  // Any lane owed is offered whenever the receiver is ready; a word is
  // taken when nothing is owed or the last owed lane is leaving.
  always @(negedge clk) begin
    bit exp_enq;
    bit exp_deq;
    exp_enq = rst_n && (exp_q.size() != 0) && receiver_full_n;
    exp_deq = rst_n && (up_q.size() != 0) && ((exp_q.size() == 0) || (exp_enq && exp_q[0].last));
    checkOutput("receiver_enq", receiver_enq, exp_enq);
    checkOutput("sender_deq", sender_deq, exp_deq);
    if (exp_enq && receiver_enq) begin
      checkOutput("receiver_data", receiver_data, exp_q[0].data);
      checkOutput("receiver_last", receiver_last, exp_q[0].last);
    end else if (!receiver_enq) begin
      checkOutput("receiver_last_idle", receiver_last, 0);
    end
    if (receiver_enq) begin
      log_d.push_back(receiver_data);
      log_l.push_back(receiver_last);
      enq_cyc.push_back(cyc);
    end
    if (sender_deq) deq_cyc.push_back(cyc);
    s_rst     = !rst_n;
    s_pop_up  = exp_deq;
    s_pop_exp = exp_enq;
    s_chg     = rst_n && change_fetch_width && (input_fetch_width != 0) && (input_fetch_width <= CW'(FW));
    s_in      = input_fetch_width;
  end

  // A word's lane count is the last legal request seen before the cycle it is taken.
  always @(posedge clk) begin
    logic [FW*DW-1:0] w;
    lane_t e;
    #1;
    cyc++;
    if (s_rst) begin
      exp_q.delete();
      model_width = FW;
    end else begin
      if (s_pop_exp) void'(exp_q.pop_front());
      if (s_pop_up) begin
        w = up_q.pop_front();
        refreshSender();
        for (int i = 0; i < model_width; i++) begin
          e.data = w[i*DW +: DW];
          e.last = (i == model_width - 1);
          exp_q.push_back(e);
        end
      end
      if (s_chg) model_width = int'(s_in);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit chg, input logic [CW-1:0] w);
    change_fetch_width = chg;
    input_fetch_width  = w;
    step();
    change_fetch_width = 1'b0;
  endtask

  task automatic pushWord(input logic [DW-1:0] base);
    up_q.push_back(mkWord(base));
    refreshSender();
  endtask

  task automatic waitDrain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (up_q.size() == 0 && exp_q.size() == 0) break;
      step();
    end
    checkOutput({name, " drained"}, (up_q.size() == 0 && exp_q.size() == 0), 1);
    step();
    step();
  endtask

  task automatic waitLog(input string name, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (log_d.size() >= n) break;
      step();
    end
    checkOutput({name, " reached lane"}, (log_d.size() >= n), 1);
  endtask

  task automatic clearLog();
    log_d.delete();
    log_l.delete();
    enq_cyc.delete();
    deq_cyc.delete();
    exp_d.delete();
    exp_l.delete();
  endtask

  task automatic expWord(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_d.push_back(base + DW'(i));
      exp_l.push_back(i == n - 1);
    end
  endtask

  task automatic checkSeq(input string name);
    checkOutput({name, " lane count"}, log_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < log_d.size()) begin
        checkOutput($sformatf("%s lane%0d data", name, i), log_d[i], exp_d[i]);
        checkOutput($sformatf("%s lane%0d last", name, i), log_l[i], exp_l[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n              = 1'b0;
    receiver_full_n    = 1'b1;
    change_fetch_width = 1'b0;
    input_fetch_width  = '0;
    refreshSender();
    step();
    @(negedge clk);
    checkOutput("reset enq", receiver_enq, 0);
    checkOutput("reset deq", sender_deq, 0);
    step();
    rst_n = 1'b1;
    step();

    // Single word at full width.
    clearLog();
    pushWord(16'h0000);
    waitDrain("single", 40);
    expWord(16'h0000, 6);
    checkSeq("single");
    checkOutput("single deq count", deq_cyc.size(), 1);
    if (enq_cyc.size() == 6) checkOutput("single span", enq_cyc[5] - enq_cyc[0], 5);

    // Two queued words stream without a bubble.
    clearLog();
    pushWord(16'h0010);
    pushWord(16'h0020);
    waitDrain("b2b", 60);
    expWord(16'h0010, 6);
    expWord(16'h0020, 6);
    checkSeq("b2b");
    checkOutput("b2b deq count", deq_cyc.size(), 2);
    if (enq_cyc.size() == 12) checkOutput("b2b span", enq_cyc[11] - enq_cyc[0], 11);
    if (enq_cyc.size() == 12 && deq_cyc.size() == 2)
      checkOutput("b2b reload on last", deq_cyc[1], enq_cyc[5]);

    // Backpressure while lane 2 is presented.
    clearLog();
    pushWord(16'h0030);
    waitLog("stall", 2, 20);
    receiver_full_n = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checkOutput("stall data", receiver_data, 16'h0032);
      checkOutput("stall enq", receiver_enq, 0);
      step();
    end
    receiver_full_n = 1'b1;
    waitDrain("stall", 40);
    expWord(16'h0030, 6);
    checkSeq("stall");

    // Width 4 set in IDLE; illegal 0 and 7 are ignored afterwards.
    clearLog();
    applyStimulus(1'b1, 3'd4);
    pushWord(16'h00A0);
    waitDrain("width4", 40);
    applyStimulus(1'b1, 3'd0);
    applyStimulus(1'b1, 3'd7);
    pushWord(16'h00B0);
    waitDrain("width4 kept", 40);
    expWord(16'h00A0, 4);
    expWord(16'h00B0, 4);
    checkSeq("width4");

    // Change to 2 during lane 1 affects only the following word.
    applyStimulus(1'b1, 3'd6);
    clearLog();
    pushWord(16'h00C0);
    pushWord(16'h00D0);
    waitLog("midword", 1, 20);
    applyStimulus(1'b1, 3'd2);
    waitDrain("midword", 60);
    expWord(16'h00C0, 6);
    expWord(16'h00D0, 2);
    checkSeq("midword");

    // Reset on lane 3 drops the rest and restores width 6.
    applyStimulus(1'b1, 3'd5);
    clearLog();
    pushWord(16'h00E0);
    waitLog("reset mid", 3, 20);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("reset mid enq", receiver_enq, 0);
    step();
    pushWord(16'h00F0);
    @(negedge clk);
    checkOutput("reset mid deq", sender_deq, 0);
    step();
    rst_n = 1'b1;
    waitDrain("reset mid", 40);
    expWord(16'h00E0, 3);
    exp_l[2] = 1'b0;
    expWord(16'h00F0, 6);
    checkSeq("reset mid");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
